// File: rtl/gpio_cmd_ctrl_pkg.sv
// Shared edge-mode encodings and the edge qualification helper for the GPIO command front end.
package gpio_cmd_ctrl_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // True when the accepted level transition old_lvl -> new_lvl matches the channel mode.
  function automatic logic qualify(input logic [1:0] mode, input logic old_lvl, input logic new_lvl);
    logic rise;
    logic fall;
    rise = !old_lvl && new_lvl;
    fall = old_lvl && !new_lvl;
    case (mode)
      EDGE_RISE: qualify = rise;
      EDGE_FALL: qualify = fall;
      EDGE_BOTH: qualify = rise || fall;
      default:   qualify = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_cmd_channel.sv
// One GPIO channel: synchroniser, debounce counter, edge qualification and sticky pending flag.
module gpio_cmd_channel
  import gpio_cmd_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned DB_W        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       gpio_in,
  input  logic [1:0] edge_sel,
  input  logic       pend_clr,
  output logic       cmd,
  output logic       level,
  output logic       pending
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   cmd_q, cmd_d;
  logic                   pend_q, pend_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state: everything holds while disabled; a new level is accepted after DB_CYCLES mismatches.
  always_comb begin
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    cmd_d   = cmd_q;
    pend_d  = pend_q;
    if (ena) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], gpio_in};
      cmd_d  = 1'b0;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = s;
        cnt_d   = '0;
        cmd_d   = qualify(edge_sel, level_q, s);
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
      pend_d = (pend_q & ~pend_clr) | cmd_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      cmd_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      cmd_q   <= cmd_d;
      pend_q  <= pend_d;
    end
  end

  // The held pulse register is masked so a disabled block never presents a command.
  assign cmd     = cmd_q & ena;
  assign level   = level_q;
  assign pending = pend_q;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Multi-channel GPIO command front end; replicates one channel per pin and slices the buses.
module gpio_cmd_ctrl #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4,
  parameter int unsigned DB_W        = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [NUM_CH-1:0]     gpio_in,
  input  logic [2*NUM_CH-1:0]   edge_sel,
  input  logic [NUM_CH-1:0]     pend_clr,
  output logic [NUM_CH-1:0]     cmd,
  output logic [NUM_CH-1:0]     level,
  output logic [NUM_CH-1:0]     pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_cmd_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .DB_W        (DB_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .gpio_in  (gpio_in[i]),
      .edge_sel (edge_sel[2*i +: 2]),
      .pend_clr (pend_clr[i]),
      .cmd      (cmd[i]),
      .level    (level[i]),
      .pending  (pending[i])
    );
  end

endmodule
